// File: rtl/disp_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a} and everything is active-low.
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int PWM_PHASES = 8;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Entry n is the active-low segment pattern for hex digit n.
  localparam logic [15:0][6:0] HEX7SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic [2:0]  bright;
    logic        blank_lz;
  } disp_buf_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7SEG[nibble_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with PWM brightness,
// leading-zero blanking and frame-synchronous double buffering.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 6250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_mask,
  input  logic [2:0]  wr_bright,
  input  logic        wr_blank_lz,
  output logic        pending,
  output logic        frame_done,
  output logic [1:0]  digit,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W    = $clog2(PWM_PHASES);
  localparam int DIG_W   = $clog2(NUM_DIGITS);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(PWM_PHASES - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic               pending_q, pending_d;
  disp_buf_t          pend_q, pend_d;
  disp_buf_t          act_q, act_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic       tick, slot_end, frame_end;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic [3:0] lz_blank;
  logic       lit;

  assign tick      = (presc_q == TICK_LAST);
  assign slot_end  = tick && (phase_q == PH_LAST);
  assign frame_end = slot_end && (digit_q == DIG_LAST);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    phase_d   = tick ? phase_q + 1'b1 : phase_q;
    digit_d   = slot_end ? digit_q + 1'b1 : digit_q;
    act_d     = act_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      act_d     = pend_q;
      pending_d = 1'b0;
    end
    // A write on the boundary cycle lands after the transfer and stays pending.
    if (wr_en) begin
      pend_d    = '{data: wr_data, dp: wr_dp, mask: wr_mask,
                    bright: wr_bright, blank_lz: wr_blank_lz};
      pending_d = 1'b1;
    end
  end

  // A digit is blank when it and every more significant nibble are zero.
  always_comb begin
    lz_blank[3] = act_q.blank_lz && (act_q.data[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (act_q.data[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (act_q.data[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
  end

  assign nibble = act_q.data[{digit_q, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    lit  = act_q.mask[digit_q] && (phase_q <= act_q.bright) && !lz_blank[digit_q];
    an_d = AN_OFF;
    seg_d = SEG_OFF;
    dp_d = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = dec_seg;
      dp_d  = ~act_q.dp[digit_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      phase_q   <= '0;
      digit_q   <= '0;
      pending_q <= 1'b0;
      pend_q    <= '0;
      act_q     <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_end;
  assign digit      = digit_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with TICK_DIV=4 (32-cycle slots, 128-cycle frames).
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_mask;
  logic [2:0]  wr_bright;
  logic        wr_blank_lz;
  logic        pending;
  logic        frame_done;
  logic [1:0]  digit;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  disp_scan_ctrl #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .wr_mask     (wr_mask),
    .wr_bright   (wr_bright),
    .wr_blank_lz (wr_blank_lz),
    .pending     (pending),
    .frame_done  (frame_done),
    .digit       (digit),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mv,
                          input logic [2:0] br, input logic blz);
    wr_data = d; wr_dp = dpv; wr_mask = mv; wr_bright = br; wr_blank_lz = blz;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge inside the next frame-boundary cycle.
  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 300);
    check(tag, frame_done, 1);
  endtask

  // Observes the next 32 output cycles: one whole digit slot.
  task automatic check_slot(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                            input int elit, input int edp);
    int lit = 0;
    int bad = 0;
    int dpl = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an !== 4'hF) begin
        lit++;
        if (an !== ean || seg !== eseg) bad++;
      end else if (seg !== 7'h7F) begin
        bad++;
      end
      if (dp === 1'b0) dpl++;
    end
    check({tag, "_lit"}, lit, elit);
    check({tag, "_pat"}, bad, 0);
    check({tag, "_dp"}, dpl, edp);
  endtask

  initial begin
    int cnt;
    int idx;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0; wr_mask = '0;
    wr_bright = '0; wr_blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_digit", digit, 2'd0);
    check("rst_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_an", an, 4'hF);
    check("post_rst_seg", seg, 7'h7F);

    // Basic display of 0x1234
    do_write(16'h1234, 4'b0000, 4'b1111, 3'd7, 1'b0);
    check("wr_pending", pending, 1'b1);
    wait_frame("fw_basic");
    check("pending_at_boundary", pending, 1'b1);
    @(negedge clk);
    check("pending_cleared", pending, 1'b0);
    check_slot("d0_4", 4'b1110, 7'b0011001, 32, 0);
    check_slot("d1_3", 4'b1101, 7'b0110000, 32, 0);
    check_slot("d2_2", 4'b1011, 7'b0100100, 32, 0);
    check_slot("d3_1", 4'b0111, 7'b1111001, 32, 0);

    // Brightness
    do_write(16'h1234, 4'b0000, 4'b1111, 3'd2, 1'b0);
    wait_frame("fw_br2");
    @(negedge clk);
    check_slot("br2", 4'b1110, 7'b0011001, 12, 0);
    do_write(16'h1234, 4'b0000, 4'b1111, 3'd0, 1'b0);
    wait_frame("fw_br0");
    @(negedge clk);
    check_slot("br0", 4'b1110, 7'b0011001, 4, 0);

    // Leading-zero blanking with a decimal point on digit 1
    do_write(16'h0050, 4'b0010, 4'b1111, 3'd7, 1'b1);
    wait_frame("fw_lz50");
    @(negedge clk);
    check_slot("lz50_d0", 4'b1110, 7'b1000000, 32, 0);
    check_slot("lz50_d1", 4'b1101, 7'b0010010, 32, 32);
    check_slot("lz50_d2", 4'b1011, 7'b1111111, 0, 0);
    check_slot("lz50_d3", 4'b0111, 7'b1111111, 0, 0);
    do_write(16'h0000, 4'b0000, 4'b1111, 3'd7, 1'b1);
    wait_frame("fw_lz00");
    @(negedge clk);
    check_slot("lz00_d0", 4'b1110, 7'b1000000, 32, 0);
    check_slot("lz00_d1", 4'b1101, 7'b1111111, 0, 0);
    check_slot("lz00_d2", 4'b1011, 7'b1111111, 0, 0);
    check_slot("lz00_d3", 4'b0111, 7'b1111111, 0, 0);

    // Last write in a frame wins
    do_write(16'hAAAA, 4'b0000, 4'b1111, 3'd7, 1'b0);
    do_write(16'h5555, 4'b0000, 4'b1111, 3'd7, 1'b0);
    wait_frame("fw_5555");
    @(negedge clk);
    check_slot("w5_d0", 4'b1110, 7'b0010010, 32, 0);
    check_slot("w5_d1", 4'b1101, 7'b0010010, 32, 0);
    check_slot("w5_d2", 4'b1011, 7'b0010010, 32, 0);
    check_slot("w5_d3", 4'b0111, 7'b0010010, 32, 0);

    // frame_done: one single-cycle pulse per 128 cycles
    cnt = 0; idx = -1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        cnt++;
        idx = i;
      end
    end
    check("fd_count", cnt, 1);
    check("fd_position", idx, 126);

    // Write coincident with the boundary waits a full frame
    wait_frame("fw_coinc");
    wr_data = 16'h1234; wr_dp = 4'b0000; wr_mask = 4'b1111; wr_bright = 3'd7; wr_blank_lz = 1'b0;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("coinc_pending", pending, 1'b1);
    check("coinc_still_5", seg, 7'b0010010);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (pending === 1'b1) cnt++;
      if (frame_done === 1'b1) break;
      @(negedge clk);
    end
    check("coinc_pending_cycles", cnt, 128);
    @(negedge clk);
    check("coinc_applied_pending", pending, 1'b0);
    check_slot("coinc_d0", 4'b1110, 7'b0011001, 32, 0);

    // Reset in the middle of the digit 2 slot with a write pending
    do_write(16'hABCD, 4'b1111, 4'b1111, 3'd7, 1'b0);
    check("mid_pending", pending, 1'b1);
    repeat (46) @(negedge clk);
    check("mid_an_d2", an, 4'b1011);
    check("mid_seg_d2", seg, 7'b0100100);
    #1 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1'b1);
    check("async_pending", pending, 1'b0);
    check("async_digit", digit, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("restart_digit0", digit, 2'd0);
    repeat (31) @(negedge clk);
    check("restart_digit_c31", digit, 2'd0);
    @(negedge clk);
    check("restart_digit_c32", digit, 2'd1);
    repeat (95) @(negedge clk);
    check("restart_fd_c127", frame_done, 1'b1);
    check("restart_pending_lost", pending, 1'b0);
    check("restart_dark", an, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
